mem_responder: RTL and testbench

- Multi-cycle data-memory responder. It serves single load/store requests from the pipeline's MEM stage, or from a future cache controller, over a valid/ready request channel and a one-cycle response pulse.
- It replaces the single-cycle data memory with a fixed, parameterised access latency so the pipeline stall logic can be exercised.
- It sits between the EX/MEM stage and the backing word array.

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bundle between a load/store requester and mem_responder.
// The master drives the request fields. The slave drives ready, busy and the response.
interface mem_responder_if;
    logic        req_valid;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        busy;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, busy, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, busy, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency data-memory responder for one load/store at a time over a valid/ready channel.
// Optional MEM_RESPONDER_ALIGN_CHECK_EN flags odd addresses with rsp_err and skips the array access.
module mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);

    localparam int          DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_wr;
    logic [DEPTH_LOG2-1:0]   r_index;
    logic [15:0]             r_wdata;
    logic                    r_rsp_valid;
    logic                    r_rsp_err;
    logic [15:0]             r_rsp_rdata;
    logic [15:0]             r_mem [0:DEPTH-1];

    logic                    w_accept;
    logic                    w_finish;
    logic                    w_misaligned;
    logic                    w_commit;
    logic                    w_unused;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    logic                    r_odd;
    assign w_misaligned = r_odd;
`else
    assign w_misaligned = 1'b0;
`endif

    // Bits above the word index alias; bit 0 only matters when the alignment check is built in.
    assign w_unused = &{1'b0, bus.req_addr[15:DEPTH_LOG2+1], bus.req_addr[0]};

    assign bus.req_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    assign w_accept = (r_state == IDLE) && bus.req_valid;
    assign w_finish = (r_state == BUSY) && (r_cnt == 4'd0);
    assign w_commit = w_finish && r_wr && !w_misaligned;

    // The array has no reset; a store lands only on the BUSY->RESP edge, so a reset mid-flight leaves it intact.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_wr        <= 1'b0;
            r_index     <= '0;
            r_wdata     <= 16'h0000;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 16'h0000;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
            r_odd       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_wr    <= bus.req_wr;
                        r_index <= bus.req_addr[DEPTH_LOG2:1];
                        r_wdata <= bus.req_wdata;
                        r_cnt   <= LAT_M1;
                        r_state <= BUSY;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
                        r_odd   <= bus.req_addr[0];
`endif
                    end
                end
                BUSY: begin
                    if (!w_finish) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_misaligned;
                        if (!r_wr && !w_misaligned) begin
                            r_rsp_rdata <= r_mem[r_index];
                        end
                    end
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, latency, handshake spacing, aliasing, reset mid-flight, LATENCY=1.
// Expectations for odd addresses follow MEM_RESPONDER_ALIGN_CHECK_EN.
module tb_mem_responder;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nFails;

    logic [15:0] rdata;
    logic        err;

    mem_responder_if bus ();
    mem_responder_if bus1 ();

    mem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // One request on the LATENCY=4 instance, checking the response lands exactly four edges after acceptance.
    task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                                 output logic [15:0] rdataOut, output logic errOut);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        stepEdge();
        bus.req_valid = 1'b0;
        checkOutput("acceptReadyLow", bus.req_ready, 16'd0);
        for (int k = 1; k < 4; k++) begin
            stepEdge();
            checkOutput("noEarlyRsp", bus.rsp_valid, 16'd0);
        end
        stepEdge();
        checkOutput("rspValidAtLatency", bus.rsp_valid, 16'd1);
        checkOutput("busyInResp", bus.busy, 16'd1);
        rdataOut = bus.rsp_rdata;
        errOut   = bus.rsp_err;
        stepEdge();
        checkOutput("rspOneCycle", bus.rsp_valid, 16'd0);
        checkOutput("readyAfterResp", bus.req_ready, 16'd1);
    endtask

    initial begin
        nChecks        = 0;
        nFails         = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_wr     = 1'b0;
        bus.req_addr   = 16'h0000;
        bus.req_wdata  = 16'h0000;
        bus1.req_valid = 1'b0;
        bus1.req_wr    = 1'b0;
        bus1.req_addr  = 16'h0000;
        bus1.req_wdata = 16'h0000;

        repeat (3) stepEdge();
        checkOutput("resetReady", bus.req_ready, 16'd1);
        checkOutput("resetBusy", bus.busy, 16'd0);
        checkOutput("resetRspValid", bus.rsp_valid, 16'd0);
        checkOutput("resetRdata", bus.rsp_rdata, 16'h0000);
        checkOutput("resetErr", bus.rsp_err, 16'd0);
        rst_n = 1'b1;
        stepEdge();

        applyStimulus(1'b1, 16'h0010, 16'h1111, rdata, err);
        applyStimulus(1'b1, 16'h0020, 16'h1234, rdata, err);
        checkOutput("storeErr", err, 16'd0);
        applyStimulus(1'b0, 16'h0020, 16'h0000, rdata, err);
        checkOutput("loadData", rdata, 16'h1234);
        checkOutput("loadErr", err, 16'd0);

        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 16'h0010;
        bus.req_wdata = 16'hBEEF;
        stepEdge();
        bus.req_valid = 1'b0;
        stepEdge();
        stepEdge();
        rst_n = 1'b0;
        #1;
        checkOutput("midResetReady", bus.req_ready, 16'd1);
        checkOutput("midResetBusy", bus.busy, 16'd0);
        checkOutput("midResetRspValid", bus.rsp_valid, 16'd0);
        checkOutput("midResetRdata", bus.rsp_rdata, 16'h0000);
        stepEdge();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            stepEdge();
            checkOutput("noRspAfterReset", bus.rsp_valid, 16'd0);
        end
        applyStimulus(1'b0, 16'h0010, 16'h0000, rdata, err);
        checkOutput("droppedStore", rdata, 16'h1111);

        // Back-to-back stores with req_valid held high; new data is presented while the previous one is busy.
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 16'h0040;
        bus.req_wdata = 16'hA001;
        stepEdge();
        for (int r = 0; r < 3; r++) begin
            checkOutput("hsReadyLowAtAccept", bus.req_ready, 16'd0);
            if (r < 2) begin
                bus.req_addr  = 16'h0040 + 16'(2 * (r + 1));
                bus.req_wdata = 16'hA001 + 16'(r + 1);
            end else begin
                bus.req_valid = 1'b0;
            end
            for (int k = 1; k <= 4; k++) begin
                stepEdge();
                checkOutput("hsReadyLowInFlight", bus.req_ready, 16'd0);
            end
            checkOutput("hsRspValid", bus.rsp_valid, 16'd1);
            stepEdge();
            checkOutput("hsReadyIdle", bus.req_ready, 16'd1);
            checkOutput("hsRspDone", bus.rsp_valid, 16'd0);
            if (r < 2) begin
                stepEdge();
            end
        end
        stepEdge();
        checkOutput("hsNoExtraAccept", bus.req_ready, 16'd1);
        applyStimulus(1'b0, 16'h0040, 16'h0000, rdata, err);
        checkOutput("hsData0", rdata, 16'hA001);
        applyStimulus(1'b0, 16'h0042, 16'h0000, rdata, err);
        checkOutput("hsData1", rdata, 16'hA002);
        applyStimulus(1'b0, 16'h0044, 16'h0000, rdata, err);
        checkOutput("hsData2", rdata, 16'hA003);

        applyStimulus(1'b1, 16'h0802, 16'hA5A5, rdata, err);
        applyStimulus(1'b0, 16'h0002, 16'h0000, rdata, err);
        checkOutput("aliasLoad", rdata, 16'hA5A5);
        applyStimulus(1'b1, 16'h0004, 16'h0F0F, rdata, err);
        checkOutput("rdataHoldOverStore", rdata, 16'hA5A5);

        applyStimulus(1'b1, 16'h0030, 16'h3333, rdata, err);
        applyStimulus(1'b1, 16'h0031, 16'h7777, rdata, err);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        checkOutput("oddStoreErr", err, 16'd1);
        checkOutput("oddStoreRdata", rdata, 16'hA5A5);
        applyStimulus(1'b0, 16'h0030, 16'h0000, rdata, err);
        checkOutput("oddStoreSkipped", rdata, 16'h3333);
        checkOutput("alignedErr", err, 16'd0);
`else
        checkOutput("oddStoreErr", err, 16'd0);
        applyStimulus(1'b0, 16'h0030, 16'h0000, rdata, err);
        checkOutput("oddStoreWritesWord", rdata, 16'h7777);
`endif

        bus1.req_valid = 1'b1;
        bus1.req_wr    = 1'b1;
        bus1.req_addr  = 16'h0006;
        bus1.req_wdata = 16'h5A5A;
        stepEdge();
        bus1.req_valid = 1'b0;
        stepEdge();
        stepEdge();
        checkOutput("lat1StoreIdle", bus1.req_ready, 16'd1);
        bus1.req_valid = 1'b1;
        bus1.req_wr    = 1'b0;
        stepEdge();
        bus1.req_valid = 1'b0;
        checkOutput("lat1BusyAfterAccept", bus1.busy, 16'd1);
        checkOutput("lat1NoRspYet", bus1.rsp_valid, 16'd0);
        stepEdge();
        checkOutput("lat1RspValid", bus1.rsp_valid, 16'd1);
        checkOutput("lat1BusyInResp", bus1.busy, 16'd1);
        checkOutput("lat1Rdata", bus1.rsp_rdata, 16'h5A5A);
        stepEdge();
        checkOutput("lat1BusyDone", bus1.busy, 16'd0);
        checkOutput("lat1RspDone", bus1.rsp_valid, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
